serial_sub_ctrl: RTL and testbench



---
 rtl/serial_sub_ctrl.sv | 176 +++++++++++++++++
 tb/tb_serial_sub_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
// Bit-serial subtract controller. A single 1-bit full-subtractor cell is
// stepped over a WIDTH-bit operand pair, LSB first, one bit per clock.
// The controller owns the borrow flip-flop, the bit counter and the
// operand/result shift registers. Requests and results use valid/ready.
//
// Optional build macro: SERIAL_SUB_BORROW_IN_EN
//   defined   -> adds input borrow_in, loaded as the LSB borrow on accept
//                (diff = a - b - borrow_in, for chained multi-word subtract)
//   undefined -> no borrow_in port, the LSB borrow is always 0
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready=1, waiting for a request; outputs keep the last result
// SHIFT | busy=1, one bit of the cell evaluated per clock, LSB first
// DONE  | out_valid=1, diff/borrow_out/zero stable until out_ready

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
    input  logic             borrow_in,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             busy
);

    // One extra counter bit so the count never wraps before the last bit.
    localparam int              CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [CW-1:0]    cnt;
    logic             brw;

    logic             cell_a;
    logic             cell_b;
    logic             cell_c;
    logic             cell_d;
    logic             cell_brw;
    logic [WIDTH:0]   d_cat;
    logic [WIDTH-1:0] d_next;

    logic             accept;
    logic             last_bit;
    logic             bin_load;

    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             zero_r;

`ifdef SERIAL_SUB_BORROW_IN_EN
    assign bin_load = borrow_in;
`else
    assign bin_load = 1'b0;
`endif

    // Full-subtractor cell and the diff shift path (new bit enters at MSB).
    // The concatenation form keeps the shift legal for WIDTH=1.
    always_comb begin
        cell_a   = a_sh[0];
        cell_b   = b_sh[0];
        cell_c   = brw;
        cell_d   = cell_a ^ cell_b ^ cell_c;
        cell_brw = (~cell_a & cell_c) | (~cell_a & cell_b) | (cell_b & cell_c);
        d_cat    = {cell_d, d_sh};
        d_next   = d_cat[WIDTH:1];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (cnt == LAST_BIT) begin
                    last_bit  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand shift registers, working diff, bit counter and borrow flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            d_sh <= '0;
            cnt  <= '0;
            brw  <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            d_sh <= '0;
            cnt  <= '0;
            brw  <= bin_load;
        end else if (busy) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            d_sh <= d_next;
            cnt  <= cnt + CW'(1);
            brw  <= cell_brw;
        end
    end

    // Result registers load only on the final bit, so the consumer never
    // sees a partial diff and the last result persists through IDLE/SHIFT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_r   <= '0;
            borrow_r <= 1'b0;
            zero_r   <= 1'b0;
        end else if (last_bit) begin
            diff_r   <= d_next;
            borrow_r <= cell_brw;
            zero_r   <= (d_next == '0);
        end
    end

    assign diff       = diff_r;
    assign borrow_out = borrow_r;
    assign zero       = zero_r;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Testbench for serial_sub_ctrl (WIDTH=8). Directed cases plus randomized
// operations checked against an arithmetic reference (a - b - borrow_in).
// Build with SERIAL_SUB_BORROW_IN_EN defined to exercise borrow_in.

module tb_serial_sub_ctrl;

    localparam int W = 8;

`ifdef SERIAL_SUB_BORROW_IN_EN
    localparam bit BIN_EN = 1'b1;
`else
    localparam bit BIN_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         zero;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
`ifdef SERIAL_SUB_BORROW_IN_EN
        .borrow_in  (bin),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, WIDTH shift cycles, optional backpressure,
    // release. poke drives junk requests during SHIFT that must be ignored.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input int bp, input bit poke);
        int           full;
        logic [W-1:0] ed;
        logic         eb;
        logic         ez;
        full = int'(av) - int'(bv) - int'(bi);
        ed   = full[W-1:0];
        eb   = (full < 0);
        ez   = (ed == '0);

        chk("idle_ready", in_ready, 1);
        a         = av;
        b         = bv;
        bin       = bi;
        in_valid  = 1'b1;
        out_ready = (bp == 0);
        tick;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        bin      = BIN_EN & 1'($urandom);
        chk("accept_busy", busy, 1);
        chk("accept_ready", in_ready, 0);

        for (int k = 1; k < W; k++) begin
            if (poke && k == 2) begin
                in_valid = 1'b1;
                a        = W'($urandom);
                b        = W'($urandom);
            end
            if (poke && k == W - 2) in_valid = 1'b0;
            tick;
            chk("shift_no_valid", out_valid, 0);
            chk("shift_ready_low", in_ready, 0);
        end
        in_valid = 1'b0;

        tick;
        chk("done_valid", out_valid, 1);
        chk("done_busy", busy, 0);
        chk("done_ready", in_ready, 0);
        chk("diff", diff, ed);
        chk("borrow_out", borrow_out, eb);
        chk("zero", zero, ez);

        for (int i = 0; i < bp; i++) begin
            tick;
            chk("bp_valid", out_valid, 1);
            chk("bp_diff", diff, ed);
            chk("bp_borrow", borrow_out, eb);
        end
        if (bp > 0) out_ready = 1'b1;
        tick;
        out_ready = 1'($urandom);
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
        chk("keep_diff", diff, ed);
        chk("keep_borrow", borrow_out, eb);
        chk("keep_zero", zero, ez);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
        chk("rst_zero", zero, 0);
        rst = 1'b0;
        tick;

        run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b1);
        run_op(8'hA7, 8'h19, 1'b0, 5, 1'b0);

        // Reset in the middle of a SHIFT, after bits 0..2 have been processed.
        a         = 8'h33;
        b         = 8'h11;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        tick;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_diff", diff, 0);
        chk("arst_borrow", borrow_out, 0);
        chk("arst_zero", zero, 0);
        tick;
        rst = 1'b0;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        tick;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_busy", busy, 0);
        run_op(8'h10, 8'h01, 1'b0, 0, 1'b0);

        if (BIN_EN) begin
            run_op(8'h10, 8'h0F, 1'b1, 0, 1'b0);
            run_op(8'h00, 8'h00, 1'b1, 2, 1'b0);
        end

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
            run_op(ra, rb, BIN_EN & 1'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick;
                chk("gap_valid", out_valid, 0);
                chk("gap_ready", in_ready, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
